// File: rtl/exc_ctrl.sv
// exc_ctrl: multi-source exception/interrupt controller for the LEGv8 datapath.
// Edge-detected IRQ lines with per-line mask, fixed-priority arbitration and a REQ/ack/ERET handshake.
module exc_ctrl #(
    parameter int                 NUM_IRQ  = 4,
    parameter logic [NUM_IRQ-1:0] MASK_RST = {NUM_IRQ{1'b1}}
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [NUM_IRQ-1:0] irq,
    input  logic               mask_we,
    input  logic [NUM_IRQ-1:0] mask_wdata,
    input  logic               bad_instr,
    input  logic               eret,
    input  logic               exc_ack,
    output logic               exc,
    output logic [3:0]         estatus,
    output logic [NUM_IRQ-1:0] irq_ack,
    output logic               in_handler,
    output logic [NUM_IRQ-1:0] pending,
    output logic               double_fault
);

    typedef enum logic [1:0] {IDLE, REQ, HANDLER} state_t;

    localparam logic [3:0] CAUSE_NONE = 4'b0000;
    localparam logic [3:0] CAUSE_BAD  = 4'b0010;

    state_t             state;
    logic [NUM_IRQ-1:0] irq_q;
    logic [NUM_IRQ-1:0] mask;
    logic [NUM_IRQ-1:0] edge_det;
    logic [NUM_IRQ-1:0] cand;
    logic [NUM_IRQ-1:0] ack_vec;
    logic               has_cand;
    logic [2:0]         win_id;

    assign edge_det = irq & ~irq_q;
    assign cand     = pending & mask;

    // NOTE: every always_comb output gets a default first so no latch is inferred.
    // Scan from the top down so the lowest-numbered candidate is the last one written.
    always_comb begin
        has_cand = 1'b0;
        win_id   = '0;
        for (int i = NUM_IRQ - 1; i >= 0; i--) begin
            if (cand[i]) begin
                has_cand = 1'b1;
                win_id   = 3'(i);
            end
        end
    end

    // One-hot clear/ack of the IRQ being taken by the datapath this cycle.
    always_comb begin
        ack_vec = '0;
        if (state == REQ && exc_ack && estatus[3]) begin
            for (int i = 0; i < NUM_IRQ; i++) begin
                ack_vec[i] = (estatus[2:0] == 3'(i));
            end
        end
    end

    // NOTE: all state uses non-blocking assignments so every flop updates from pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= IDLE;
            exc          <= 1'b0;
            estatus      <= CAUSE_NONE;
            irq_ack      <= '0;
            in_handler   <= 1'b0;
            pending      <= '0;
            double_fault <= 1'b0;
            irq_q        <= '0;
            mask         <= MASK_RST;
        end else begin
            irq_q   <= irq;
            // A fresh edge wins over the acknowledge clear in the same cycle.
            pending <= (pending & ~ack_vec) | edge_det;
            irq_ack <= ack_vec;
            if (mask_we) begin
                mask <= mask_wdata;
            end
            if (bad_instr && state != IDLE) begin
                double_fault <= 1'b1;
            end

            unique case (state)
                IDLE: begin
                    if (bad_instr) begin
                        state   <= REQ;
                        exc     <= 1'b1;
                        estatus <= CAUSE_BAD;
                    end else if (has_cand) begin
                        state   <= REQ;
                        exc     <= 1'b1;
                        estatus <= {1'b1, win_id};
                    end
                end
                REQ: begin
                    if (exc_ack) begin
                        state      <= HANDLER;
                        exc        <= 1'b0;
                        in_handler <= 1'b1;
                    end
                end
                HANDLER: begin
                    if (eret) begin
                        state      <= IDLE;
                        in_handler <= 1'b0;
                        estatus    <= CAUSE_NONE;
                    end
                end
                default: begin
                    state      <= IDLE;
                    exc        <= 1'b0;
                    in_handler <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_exc_ctrl.sv
// Self-checking bench for exc_ctrl: directed scenarios with literal expectations,
// then randomized traffic compared against a transaction-level reference model.
module tb_exc_ctrl;

    localparam int N = 4;

    logic         clk;
    logic         reset;
    logic [N-1:0] irq;
    logic         mask_we;
    logic [N-1:0] mask_wdata;
    logic         bad_instr;
    logic         eret;
    logic         exc_ack;
    logic         exc;
    logic [3:0]   estatus;
    logic [N-1:0] irq_ack;
    logic         in_handler;
    logic [N-1:0] pending;
    logic         double_fault;

    int n_pass  = 0;
    int n_total = 0;

    exc_ctrl #(.NUM_IRQ(N), .MASK_RST({N{1'b1}})) dut (
        .clk          (clk),
        .reset        (reset),
        .irq          (irq),
        .mask_we      (mask_we),
        .mask_wdata   (mask_wdata),
        .bad_instr    (bad_instr),
        .eret         (eret),
        .exc_ack      (exc_ack),
        .exc          (exc),
        .estatus      (estatus),
        .irq_ack      (irq_ack),
        .in_handler   (in_handler),
        .pending      (pending),
        .double_fault (double_fault)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: the controller seen as "a request is outstanding", "a handler is
    // running" and "the current cause number", advanced once per clock from the sampled inputs.
    typedef struct packed {
        logic [N-1:0] prev;
        logic [N-1:0] pend;
        logic [N-1:0] mask;
        logic [N-1:0] ack;
        logic         wait_ack;
        logic         busy;
        logic         df;
        logic [3:0]   cause;
    } model_t;

    model_t m = '0;

    function automatic model_t model_next(model_t cur);
        model_t nx;
        int     ack_id;
        int     win;
        nx = cur;
        if (reset) begin
            nx      = '0;
            nx.mask = '1;
            return nx;
        end
        ack_id = -1;
        if (cur.wait_ack) begin
            if (exc_ack) begin
                nx.wait_ack = 1'b0;
                nx.busy     = 1'b1;
                if (int'(cur.cause) >= 8) ack_id = int'(cur.cause) - 8;
            end
        end else if (cur.busy) begin
            if (eret) begin
                nx.busy  = 1'b0;
                nx.cause = 4'd0;
            end
        end else if (bad_instr) begin
            nx.cause    = 4'd2;
            nx.wait_ack = 1'b1;
        end else begin
            win = -1;
            for (int i = 0; i < N; i++) begin
                if (win < 0 && cur.pend[i] && cur.mask[i]) win = i;
            end
            if (win >= 0) begin
                nx.cause    = 4'(8 + win);
                nx.wait_ack = 1'b1;
            end
        end
        for (int i = 0; i < N; i++) begin
            if (irq[i] && !cur.prev[i]) nx.pend[i] = 1'b1;
            else if (i == ack_id)       nx.pend[i] = 1'b0;
            nx.ack[i] = (i == ack_id);
        end
        if (bad_instr && (cur.wait_ack || cur.busy)) nx.df = 1'b1;
        if (mask_we) nx.mask = mask_wdata;
        nx.prev = irq;
        return nx;
    endfunction

    always @(posedge clk) m <= model_next(m);

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        irq        = '0;
        mask_we    = 1'b0;
        mask_wdata = '0;
        bad_instr  = 1'b0;
        eret       = 1'b0;
        exc_ack    = 1'b0;
    endtask

    task automatic apply_reset();
        clear_inputs();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        apply_reset();
        n_total++; if ({exc, estatus, irq_ack, in_handler, pending, double_fault} !== '0) $display("FAIL reset_outputs: got exc=%b estatus=%b irq_ack=%b in_handler=%b pending=%b df=%b, expected all 0", exc, estatus, irq_ack, in_handler, pending, double_fault); else n_pass++;
        tick();
        n_total++; if (exc !== 1'b0 || pending !== 4'b0000) $display("FAIL reset_idle: exc=%b pending=%b expected 0/0000", exc, pending); else n_pass++;
    endtask

    task automatic test_single_irq();
        irq = 4'b0100;
        tick();
        n_total++; if (pending !== 4'b0100 || exc !== 1'b0) $display("FAIL irq2_pending: pending=%b exc=%b expected 0100/0", pending, exc); else n_pass++;
        irq = 4'b0000;
        tick();
        n_total++; if (exc !== 1'b1 || estatus !== 4'b1010) $display("FAIL irq2_req: exc=%b estatus=%b expected 1/1010", exc, estatus); else n_pass++;
        exc_ack = 1'b1;
        tick();
        n_total++; if (irq_ack !== 4'b0100 || exc !== 1'b0 || in_handler !== 1'b1 || pending !== 4'b0000) $display("FAIL irq2_ack: irq_ack=%b exc=%b in_handler=%b pending=%b expected 0100/0/1/0000", irq_ack, exc, in_handler, pending); else n_pass++;
        exc_ack = 1'b0;
        tick();
        n_total++; if (irq_ack !== 4'b0000 || estatus !== 4'b1010 || in_handler !== 1'b1) $display("FAIL irq2_handler: irq_ack=%b estatus=%b in_handler=%b expected 0000/1010/1", irq_ack, estatus, in_handler); else n_pass++;
        eret = 1'b1;
        tick();
        eret = 1'b0;
        n_total++; if (estatus !== 4'b0000 || in_handler !== 1'b0 || exc !== 1'b0) $display("FAIL irq2_eret: estatus=%b in_handler=%b exc=%b expected 0000/0/0", estatus, in_handler, exc); else n_pass++;
    endtask

    task automatic test_priority();
        irq = 4'b1010;
        tick();
        irq = 4'b0000;
        tick();
        n_total++; if (exc !== 1'b1 || estatus !== 4'b1001) $display("FAIL prio_first: exc=%b estatus=%b expected 1/1001", exc, estatus); else n_pass++;
        exc_ack = 1'b1;
        tick();
        exc_ack = 1'b0;
        n_total++; if (irq_ack !== 4'b0010 || pending !== 4'b1000) $display("FAIL prio_ack1: irq_ack=%b pending=%b expected 0010/1000", irq_ack, pending); else n_pass++;
        eret = 1'b1;
        tick();
        eret = 1'b0;
        n_total++; if (in_handler !== 1'b0 || exc !== 1'b0) $display("FAIL prio_eret: in_handler=%b exc=%b expected 0/0", in_handler, exc); else n_pass++;
        tick();
        n_total++; if (exc !== 1'b1 || estatus !== 4'b1011) $display("FAIL prio_second: exc=%b estatus=%b expected 1/1011", exc, estatus); else n_pass++;
        exc_ack = 1'b1;
        tick();
        exc_ack = 1'b0;
        n_total++; if (irq_ack !== 4'b1000 || pending !== 4'b0000) $display("FAIL prio_ack3: irq_ack=%b pending=%b expected 1000/0000", irq_ack, pending); else n_pass++;
        eret = 1'b1;
        tick();
        eret = 1'b0;
    endtask

    task automatic test_bad_vs_irq();
        irq = 4'b0001;
        tick();
        irq       = 4'b0000;
        bad_instr = 1'b1;
        tick();
        bad_instr = 1'b0;
        n_total++; if (exc !== 1'b1 || estatus !== 4'b0010 || pending !== 4'b0001) $display("FAIL bad_wins: exc=%b estatus=%b pending=%b expected 1/0010/0001", exc, estatus, pending); else n_pass++;
        exc_ack = 1'b1;
        tick();
        exc_ack = 1'b0;
        n_total++; if (irq_ack !== 4'b0000 || pending !== 4'b0001 || in_handler !== 1'b1) $display("FAIL bad_ack: irq_ack=%b pending=%b in_handler=%b expected 0000/0001/1", irq_ack, pending, in_handler); else n_pass++;
        eret = 1'b1;
        tick();
        eret = 1'b0;
        tick();
        n_total++; if (exc !== 1'b1 || estatus !== 4'b1000 || double_fault !== 1'b0) $display("FAIL bad_then_irq0: exc=%b estatus=%b df=%b expected 1/1000/0", exc, estatus, double_fault); else n_pass++;
        exc_ack = 1'b1;
        tick();
        exc_ack = 1'b0;
        n_total++; if (irq_ack !== 4'b0001 || pending !== 4'b0000) $display("FAIL irq0_ack: irq_ack=%b pending=%b expected 0001/0000", irq_ack, pending); else n_pass++;
        eret = 1'b1;
        tick();
        eret = 1'b0;
    endtask

    task automatic test_mask();
        mask_we    = 1'b1;
        mask_wdata = 4'b1110;
        tick();
        mask_we = 1'b0;
        irq     = 4'b0001;
        tick();
        irq = 4'b0000;
        n_total++; if (pending !== 4'b0001) $display("FAIL mask_pending: pending=%b expected 0001", pending); else n_pass++;
        tick();
        tick();
        n_total++; if (exc !== 1'b0 || pending !== 4'b0001) $display("FAIL mask_blocks: exc=%b pending=%b expected 0/0001", exc, pending); else n_pass++;
        mask_we    = 1'b1;
        mask_wdata = 4'b1111;
        tick();
        mask_we = 1'b0;
        n_total++; if (exc !== 1'b0) $display("FAIL mask_old_used: exc=%b expected 0", exc); else n_pass++;
        tick();
        n_total++; if (exc !== 1'b1 || estatus !== 4'b1000) $display("FAIL mask_enable: exc=%b estatus=%b expected 1/1000", exc, estatus); else n_pass++;
        exc_ack = 1'b1;
        tick();
        exc_ack = 1'b0;
        eret    = 1'b1;
        tick();
        eret = 1'b0;
    endtask

    task automatic test_double_fault();
        irq = 4'b0010;
        tick();
        irq = 4'b0000;
        tick();
        exc_ack = 1'b1;
        tick();
        exc_ack   = 1'b0;
        bad_instr = 1'b1;
        tick();
        bad_instr = 1'b0;
        n_total++; if (double_fault !== 1'b1 || estatus !== 4'b1001 || in_handler !== 1'b1 || exc !== 1'b0) $display("FAIL dfault_set: df=%b estatus=%b in_handler=%b exc=%b expected 1/1001/1/0", double_fault, estatus, in_handler, exc); else n_pass++;
        eret = 1'b1;
        tick();
        eret = 1'b0;
        n_total++; if (in_handler !== 1'b0 || estatus !== 4'b0000 || double_fault !== 1'b1) $display("FAIL dfault_eret: in_handler=%b estatus=%b df=%b expected 0/0000/1", in_handler, estatus, double_fault); else n_pass++;
        tick();
        n_total++; if (exc !== 1'b0) $display("FAIL dfault_idle: exc=%b expected 0", exc); else n_pass++;
    endtask

    task automatic test_reset_in_req();
        irq = 4'b0100;
        tick();
        tick();
        n_total++; if (exc !== 1'b1 || estatus !== 4'b1010) $display("FAIL rst_req_setup: exc=%b estatus=%b expected 1/1010", exc, estatus); else n_pass++;
        reset = 1'b1;
        tick();
        reset = 1'b0;
        n_total++; if ({exc, estatus, irq_ack, in_handler, pending, double_fault} !== '0) $display("FAIL rst_in_req: got exc=%b estatus=%b irq_ack=%b in_handler=%b pending=%b df=%b, expected all 0", exc, estatus, irq_ack, in_handler, pending, double_fault); else n_pass++;
        tick();
        n_total++; if (pending !== 4'b0100 || exc !== 1'b0) $display("FAIL rst_reedge: pending=%b exc=%b expected 0100/0", pending, exc); else n_pass++;
        tick();
        n_total++; if (exc !== 1'b1 || estatus !== 4'b1010) $display("FAIL rst_rereq: exc=%b estatus=%b expected 1/1010", exc, estatus); else n_pass++;
        apply_reset();
    endtask

    task automatic test_random();
        logic [N+N+N+7:0] exp_v;
        logic [N+N+N+7:0] got_v;
        apply_reset();
        for (int c = 0; c < 600; c++) begin
            if ($urandom_range(3) == 0) irq = N'($urandom);
            bad_instr  = ($urandom_range(19) == 0);
            exc_ack    = ($urandom_range(2) == 0);
            eret       = ($urandom_range(3) == 0);
            mask_we    = ($urandom_range(15) == 0);
            mask_wdata = N'($urandom);
            reset      = ($urandom_range(99) == 0);
            tick();
            exp_v = {m.wait_ack, m.cause, m.ack, m.busy, m.pend, m.df};
            got_v = {exc, estatus, irq_ack, in_handler, pending, double_fault};
            n_total++; if (got_v !== exp_v) $display("FAIL random_cycle_%0d: exc/estatus/irq_ack/in_handler/pending/df got %b/%b/%b/%b/%b/%b expected %b/%b/%b/%b/%b/%b", c, exc, estatus, irq_ack, in_handler, pending, double_fault, m.wait_ack, m.cause, m.ack, m.busy, m.pend, m.df); else n_pass++;
        end
        clear_inputs();
        reset = 1'b0;
    endtask

    initial begin
        reset = 1'b1;
        clear_inputs();
        test_reset();
        test_single_irq();
        test_priority();
        test_bad_vs_irq();
        test_mask();
        test_double_fault();
        test_reset_in_req();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/exc_ctrl.md
# exc_ctrl

Multi-channel exception/interrupt controller for the LEGv8 processor. It generalises single-line external-IRQ handling to NUM_IRQ edge-triggered interrupt sources, each with its own pending bit and mask. It adds fixed-priority arbitration, a request/acknowledge handshake with the datapath, and a handler-active state that is closed by ERET. It sits beside the main decoder:

- The decoder supplies `bad_instr` and `eret`.
- The datapath consumes `exc` and `estatus` to vector into the handler and to load the ESR.

## Interface
- NUM_IRQ, 4: number of external interrupt lines, legal range 1..8.
- MASK_RST, all ones (NUM_IRQ bits): reset value of the enable mask.

- clk  in  1  clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-high reset.
- irq  in  NUM_IRQ  external interrupt lines, level inputs; the block detects their rising edges.
- mask_we  in  1  writes `mask_wdata` into the enable mask.
- mask_wdata  in  NUM_IRQ  new enable mask; bit set = line enabled.
- bad_instr  in  1  decoder flags the current opcode as not-an-instruction.
- eret  in  1  decoder flags an ERET instruction.
- exc_ack  in  1  datapath has taken the exception vector.
- exc  out  1  exception request to the datapath.
- estatus  out  4  exception cause code.
- irq_ack  out  NUM_IRQ  one-cycle, one-hot pulse to the serviced source.
- in_handler  out  1  handler is active; new exceptions are held off.
- pending  out  NUM_IRQ  registered pending bits.
- double_fault  out  1  sticky flag: `bad_instr` seen while not IDLE.

## Operation
- Cause codes on `estatus`:
  - 4'b0000: none.
  - 4'b0010: invalid instruction.
  - {1'b1, id[2:0]}: external IRQ number `id`.
- Edge detect:
  - `irq_q` <= `irq` every cycle.
  - `pending[i]` is set when `irq[i] & ~irq_q[i]`.
  - An edge on a bit that is already pending is absorbed; no count is kept.
- Clearing: `pending[i]` clears only on acknowledge of IRQ `i`. A new edge on the same bit in that same cycle wins, so the bit stays set.
- Arbitration:
  - A candidate is any line with `pending & mask` set.
  - Fixed priority: the lowest index wins.
  - `bad_instr` has priority over all IRQs.
- Masked pending bits stay pending. They become eligible in the cycle after the mask is enabled.
- FSM states: IDLE, REQ, HANDLER.
- IDLE:
  - If `bad_instr`: go to REQ and latch `estatus` = 0010.
  - Otherwise, if a candidate exists: go to REQ and latch `estatus` = {1, winner id}.
  - `exc_ack` and `eret` are ignored.
- REQ:
  - `exc` = 1 and `estatus` is held.
  - On `exc_ack`: go to HANDLER.
  - If the cause is IRQ `i`, the same edge clears `pending[i]` and drives `irq_ack[i]` = 1 for the following cycle.
  - `eret` is ignored.
- HANDLER:
  - `in_handler` = 1, `exc` = 0, `estatus` is held for ESR reads.
  - On `eret`: go to IDLE and clear `estatus` to 0000.
  - There is no nesting. Pending bits keep accumulating.
- `bad_instr` in REQ or HANDLER sets `double_fault`. State and `estatus` are unchanged. The flag clears only on reset.
- Mask update:
  - On `mask_we`, the mask loads at the edge.
  - Arbitration in the same cycle uses the old mask.
  - A mask change never withdraws a request already in REQ.

## Timing
- Reset values (registered, taking effect at the next edge with `reset`=1):
  - state IDLE.
  - `exc` 0, `estatus` 0000, `irq_ack` 0, `in_handler` 0, `pending` 0, `double_fault` 0.
  - `irq_q` 0, mask = MASK_RST.
- `reset` mid-operation, in any state, returns to IDLE and drops pending requests. A line held high through reset produces a new edge on the first cycle after reset, because `irq_q` resets to 0.
- IRQ latency, for `irq[i]` rising and first sampled high at edge t with the line enabled and the FSM in IDLE:
  - `pending[i]`=1 after edge t.
  - `exc`=1 after edge t+1.
- `bad_instr` latency: sampled in IDLE at edge t gives `exc`=1 after edge t.
- Acknowledge: `exc_ack` sampled at edge t gives `exc`=0, `in_handler`=1 and `irq_ack` pulse high for the cycle after t.
- ERET: `eret` sampled at edge t gives `in_handler`=0 after t. The earliest next `exc` is after edge t+1.
- `irq_ack` is never high for more than one cycle per acknowledge.
- `exc` and `in_handler` are never high together.

## Test plan
- After reset, pulse `irq[2]`, then `exc_ack` 2 cycles later, then `eret`:
  - `exc` after 2 edges with `estatus`=4'b1010.
  - `irq_ack`=4'b0100 for one cycle.
  - `pending[2]`=0.
  - `estatus`=0 after `eret`.
- `irq[3]` and `irq[1]` rise together:
  - IRQ1 is serviced first (`estatus`=1001).
  - After `eret`, IRQ3 is serviced (`estatus`=1011) without a new edge.
- `bad_instr` and a pending enabled IRQ0 in the same IDLE cycle:
  - `estatus`=0010.
  - `pending[0]` remains 1 and is serviced after `eret`.
- `mask_wdata`=4'b1110 with `irq[0]` pulsed:
  - `pending[0]`=1 and `exc` stays 0.
  - Writing mask 4'b1111 gives `exc` within 2 cycles with `estatus`=1000.
- `bad_instr` in HANDLER: `double_fault`=1, `estatus` unchanged, `eret` still returns to IDLE.
- Assert `reset` while in REQ with `irq` held high:
  - All outputs are 0 after the reset edge.
  - `pending` is set again the first cycle after reset, and `exc` follows one edge later.
